// File: rtl/shared_reg_pkg.sv
// Shared types and constants for the shared-register arbiter.
package shared_reg_pkg;
  localparam int CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;
endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin pick: first set req bit at or after rr_ptr, circular ascending.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr_ptr,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    int p;
    p   = 0;
    idx = '0;
    any = 1'b0;
    // Walk offsets from farthest to nearest so the nearest set bit wins.
    for (int k = NREQ - 1; k >= 0; k--) begin
      p = int'(rr_ptr) + k;
      if (p >= NREQ) p = p - NREQ;
      if (req[IW'(p)]) begin
        idx = IW'(p);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one requester per two cycles write access to a shared register.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [DW-1:0]        q,
  output logic                 q_valid,
  output logic                 busy,
  output logic [CNT_W-1:0]     wr_cnt
);
  localparam int IW = $clog2(NREQ);

  state_e          state, state_nxt;
  logic [IW-1:0]   rr_ptr, idx_q, pick_idx;
  logic            pick_any;
  logic            do_write;
  logic [NREQ-1:0] gnt_nxt;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_any) state_nxt = WRITE;
      WRITE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state == WRITE);
    do_write = (state == WRITE);
    gnt_nxt  = '0;
    if (state == IDLE && pick_any) gnt_nxt[pick_idx] = 1'b1;
  end

  // gnt is registered so it is high exactly during the WRITE cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      idx_q   <= '0;
      gnt     <= '0;
      q       <= '0;
      q_valid <= 1'b0;
      wr_cnt  <= '0;
    end else begin
      gnt <= gnt_nxt;
      if (state == IDLE && pick_any) idx_q <= pick_idx;
      if (do_write) begin
        q       <= wdata[int'(idx_q)*DW +: DW];
        q_valid <= 1'b1;
        if (wr_cnt != '1) wr_cnt <= wr_cnt + 1'b1;
        rr_ptr  <= (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench: directed scenarios plus randomized requesters against a behavioural model.
module tb_shared_reg_arbiter;
  localparam int N  = 4;
  localparam int N3 = 3;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N*DW-1:0] wdata = '0;
  logic [N-1:0]    gnt;
  logic [DW-1:0]   q;
  logic            q_valid, busy;
  logic [15:0]     wr_cnt;

  logic [N3-1:0]    req3 = '0;
  logic [N3*DW-1:0] wdata3 = '0;
  logic [N3-1:0]    gnt3;
  logic [DW-1:0]    q3;
  logic             qv3, busy3;
  logic [15:0]      cnt3;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  bit          m_wr = 0;
  int          m_idx = 0, m_ptr = 0, m_cnt = 0;
  logic [N-1:0] m_gnt = '0;
  logic [DW-1:0] m_q = '0;
  bit          m_qv = 0;

  shared_reg_arbiter #(.NREQ(N), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wdata(wdata),
    .gnt(gnt), .q(q), .q_valid(q_valid), .busy(busy), .wr_cnt(wr_cnt)
  );

  shared_reg_arbiter #(.NREQ(N3), .DW(DW)) dut3 (
    .clk(clk), .rst_n(rst_n), .req(req3), .wdata(wdata3),
    .gnt(gnt3), .q(q3), .q_valid(qv3), .busy(busy3), .wr_cnt(cnt3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic model_edge();
    bit found;
    int i;
    found = 0;
    if (!rst_n) begin
      m_wr = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
      m_gnt = '0; m_q = '0; m_qv = 0;
    end else if (m_wr) begin
      m_q   = wdata[m_idx*DW +: DW];
      m_qv  = 1;
      m_cnt = (m_cnt >= 16'hFFFF) ? 16'hFFFF : m_cnt + 1;
      m_ptr = (m_idx + 1) % N;
      m_wr  = 0;
      m_gnt = '0;
    end else begin
      m_gnt = '0;
      for (int k = 0; k < N; k++) begin
        i = (m_ptr + k) % N;
        if (!found && req[i]) begin
          found = 1;
          m_idx = i;
          m_wr  = 1;
          m_gnt = N'(1 << i);
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("gnt", gnt, m_gnt);
    chk("q", q, m_q);
    chk("q_valid", q_valid, m_qv);
    chk("busy", busy, m_wr);
    chk("wr_cnt", wr_cnt, m_cnt);
  endtask

  initial begin
    rst_n = 1'b0;
    step(); step();
    chk("rst_gnt3", gnt3, 0);
    chk("rst_q3", q3, 0);

    // Single request, latency
    rst_n = 1'b1;
    req = 4'b0100;
    wdata[2*DW +: DW] = 8'hA5;
    step();
    chk("lat_gnt", gnt, 4'b0100);
    req = '0;
    step();
    chk("lat_q", q, 8'hA5);
    chk("lat_qv", q_valid, 1);
    chk("lat_cnt", wr_cnt, 1);

    // All requesting from reset: strict rotation, one write per two cycles
    rst_n = 1'b0;
    req = 4'b1111;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    step();
    rst_n = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c % 2 == 1) chk("rr_gnt", gnt, 32'(1 << (((c - 1) / 2) % 4)));
      else            chk("rr_gap", gnt, 0);
    end
    chk("rr_cnt", wr_cnt, 5);
    chk("rr_q", q, 8'h11);

    // Pointer at 3 after granting 2
    req = 4'b0100;
    step();
    chk("p3_gnt2", gnt, 4'b0100);
    req = '0;
    step();
    req = 4'b1001;
    step();
    chk("p3_gnt3", gnt, 4'b1000);
    step();
    step();
    chk("p3_gnt0", gnt, 4'b0001);
    req = '0;
    step();
    step();

    // Reset during WRITE aborts the write
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req = 4'b0001;
    wdata[0 +: DW] = 8'h3C;
    step();
    chk("abort_gnt", gnt, 4'b0001);
    rst_n = 1'b0;
    req = '0;
    step();
    chk("abort_gnt0", gnt, 0);
    chk("abort_q", q, 0);
    chk("abort_qv", q_valid, 0);
    chk("abort_cnt", wr_cnt, 0);
    rst_n = 1'b1;
    step();
    chk("abort_q2", q, 0);
    chk("abort_cnt2", wr_cnt, 0);

    // Counter saturation
    force dut.wr_cnt = 16'hFFFE;
    #1;
    release dut.wr_cnt;
    m_cnt = 16'hFFFE;
    req = 4'b0010;
    for (int w = 0; w < 3; w++) begin
      step();
      step();
      chk("sat_cnt", wr_cnt, 16'hFFFF);
    end
    req = '0;
    step();

    // Non-power-of-two wrap
    req3 = 3'b111;
    wdata3 = {8'hC2, 8'hB1, 8'hA0};
    for (int c = 1; c <= 8; c++) begin
      step();
      if (c % 2 == 1) chk("n3_gnt", gnt3, 32'(1 << (((c - 1) / 2) % 3)));
      else            chk("n3_gap", gnt3, 0);
    end
    chk("n3_q", q3, 8'hA0);
    chk("n3_cnt", cnt3, 4);
    req3 = '0;

    // Randomized requesters obeying hold-until-grant
    for (int c = 0; c < 600; c++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      for (int i = 0; i < N; i++) begin
        if (gnt[i]) req[i] = 1'b0;
        else if (!req[i] && ($urandom_range(0, 2) == 0)) begin
          req[i] = 1'b1;
          wdata[i*DW +: DW] = 8'($urandom);
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
